mpu_frame_packer: RTL and testbench

- Sits directly downstream of the I2C master that burst-reads the MPU6050 starting at register 0x3B.
- Collects the byte stream (byte_data qualified by byte_valid) into one 14-byte sensor frame.
- Converts the frame to signed 16-bit words: accel X/Y/Z, temperature, gyro X/Y/Z.
- Publishes all seven words atomically with a single-cycle frame_valid strobe for the attitude/control logic.

---
 rtl/mpu_frame_packer.sv | 160 ++++++++++++++++
 tb/tb_mpu_frame_packer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_frame_packer.sv
// Packs the MPU6050 burst read (starting at reg 0x3B) into seven signed words published atomically.
// Optional build macro MPU_FRAME_GYRO_OFFSET_EN adds saturating gyro calibration offsets.
module mpu_frame_packer #(
   parameter int NUM_BYTES   = 14,
   parameter int GAP_TIMEOUT = 5000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
`ifdef MPU_FRAME_GYRO_OFFSET_EN
   input  logic signed [15:0] gyro_off_x,
   input  logic signed [15:0] gyro_off_y,
   input  logic signed [15:0] gyro_off_z,
`endif
   output logic signed [15:0] accel_x,
   output logic signed [15:0] accel_y,
   output logic signed [15:0] accel_z,
   output logic signed [15:0] temp,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic               frame_valid,
   output logic               frame_err,
   output logic [15:0]        frame_cnt,
   output logic               busy
);
   // state   | meaning
   // IDLE    | waiting for frame_start; stray bytes dropped
   // COLLECT | filling shadow buffer, gap timer running
   // PUBLISH | one cycle: shadow copied to word outputs

   localparam int NW = NUM_BYTES / 2;
   localparam int GW = $clog2(GAP_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

   state_t             state;
   logic [3:0]         byte_cnt;
   logic [GW-1:0]      gap_cnt;
   logic [7:0]         shadow [14];
   logic signed [15:0] word [7];
   logic signed [15:0] pub_gx, pub_gy, pub_gz;

   always_comb begin
      for (int k = 0; k < 7; k++) begin
         word[k] = (k < NW) ? {shadow[2*k], shadow[2*k+1]} : 16'sd0;
      end
   end

`ifdef MPU_FRAME_GYRO_OFFSET_EN
   function automatic logic signed [15:0] sub_sat(input logic signed [15:0] a,
                                                  input logic signed [15:0] b);
      logic [16:0] d;
      d = {a[15], a} - {b[15], b};
      case (d[16:15])
         2'b01:   sub_sat = 16'sh7FFF;
         2'b10:   sub_sat = 16'sh8000;
         default: sub_sat = d[15:0];
      endcase
   endfunction

   // absent gyro words stay 0 rather than showing the negated offset
   assign pub_gx = (NW > 4) ? sub_sat(word[4], gyro_off_x) : 16'sd0;
   assign pub_gy = (NW > 5) ? sub_sat(word[5], gyro_off_y) : 16'sd0;
   assign pub_gz = (NW > 6) ? sub_sat(word[6], gyro_off_z) : 16'sd0;
`else
   assign pub_gx = word[4];
   assign pub_gy = word[5];
   assign pub_gz = word[6];
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         byte_cnt    <= '0;
         gap_cnt     <= '0;
         for (int i = 0; i < 14; i++) shadow[i] <= '0;
         accel_x     <= '0;
         accel_y     <= '0;
         accel_z     <= '0;
         temp        <= '0;
         gyro_x      <= '0;
         gyro_y      <= '0;
         gyro_z      <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         case (state)
            IDLE, PUBLISH: begin
               if (state == PUBLISH) begin
                  accel_x     <= word[0];
                  accel_y     <= word[1];
                  accel_z     <= word[2];
                  temp        <= word[3];
                  gyro_x      <= pub_gx;
                  gyro_y      <= pub_gy;
                  gyro_z      <= pub_gz;
                  frame_valid <= 1'b1;
                  frame_cnt   <= frame_cnt + 16'd1;
               end
               gap_cnt <= '0;
               if (frame_start) begin
                  state <= COLLECT;
                  if (byte_valid) begin
                     shadow[0] <= byte_data;
                     byte_cnt  <= 4'd1;
                  end else begin
                     byte_cnt  <= 4'd0;
                  end
               end else begin
                  state    <= IDLE;
                  byte_cnt <= 4'd0;
               end
            end
            COLLECT: begin
               if (frame_start) begin
                  frame_err <= 1'b1;
                  gap_cnt   <= '0;
                  if (byte_valid) begin
                     shadow[0] <= byte_data;
                     byte_cnt  <= 4'd1;
                  end else begin
                     byte_cnt  <= 4'd0;
                  end
               end else if (byte_cnt >= 4'(NUM_BYTES)) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
                  byte_cnt  <= 4'd0;
                  gap_cnt   <= '0;
               end else if (byte_valid) begin
                  shadow[byte_cnt] <= byte_data;
                  byte_cnt         <= byte_cnt + 4'd1;
                  gap_cnt          <= '0;
                  if (byte_cnt == 4'(NUM_BYTES - 1)) state <= PUBLISH;
               end else if (gap_cnt == GW'(GAP_TIMEOUT - 1)) begin
                  // shadow is left stale; the next full frame overwrites every slot
                  frame_err <= 1'b1;
                  state     <= IDLE;
                  byte_cnt  <= 4'd0;
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               byte_cnt <= 4'd0;
               gap_cnt  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mpu_frame_packer.sv
// Testbench for mpu_frame_packer: per-cycle comparison against a queue-based frame model,
// a hand-derived vector table, directed corner sequences and a randomized phase.
module tb_mpu_frame_packer;
   localparam int NB  = 14;
   localparam int GAP = 5000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic signed [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
   logic        frame_valid, frame_err, busy;
   logic [15:0] frame_cnt;
`ifdef MPU_FRAME_GYRO_OFFSET_EN
   logic signed [15:0] gyro_off_x = 16'sd0;
   logic signed [15:0] gyro_off_y = 16'sd0;
   logic signed [15:0] gyro_off_z = 16'sd0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mpu_frame_packer #(.NUM_BYTES(NB), .GAP_TIMEOUT(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .byte_valid(byte_valid), .byte_data(byte_data),
`ifdef MPU_FRAME_GYRO_OFFSET_EN
      .gyro_off_x(gyro_off_x), .gyro_off_y(gyro_off_y), .gyro_off_z(gyro_off_z),
`endif
      .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
      .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .busy(busy)
   );

   // reference model: a frame is a queue of bytes; publication lags completion by one edge
   logic [7:0]  q[$];
   bit          in_frame, pend, m_fv, m_err;
   int          idle_cycles;
   logic [15:0] m_words[7];
   logic [15:0] pend_words[7];
   logic [15:0] m_cnt;

   function automatic logic [15:0] sat_sub(logic [15:0] raw, logic [15:0] off);
      int v;
      v = int'($signed(raw)) - int'($signed(off));
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      return 16'(v);
   endfunction

   task automatic model_reset();
      q.delete();
      in_frame = 0; pend = 0; m_fv = 0; m_err = 0;
      idle_cycles = 0; m_cnt = 16'h0;
      for (int k = 0; k < 7; k++) m_words[k] = 16'h0;
   endtask

   task automatic model_step(bit fs, bit bv, logic [7:0] bd);
      m_fv = 0; m_err = 0;
      if (pend) begin
         m_words = pend_words;
         m_cnt++;
         m_fv = 1;
         pend = 0;
      end
      if (fs) begin
         if (in_frame) m_err = 1;
         in_frame = 1;
         q.delete();
         idle_cycles = 0;
         if (bv) q.push_back(bd);
      end else if (in_frame) begin
         if (bv) begin
            q.push_back(bd);
            idle_cycles = 0;
            if (q.size() == NB) begin
               for (int k = 0; k < 7; k++)
                  pend_words[k] = (2*k+1 < NB) ? {q[2*k], q[2*k+1]} : 16'h0;
`ifdef MPU_FRAME_GYRO_OFFSET_EN
               pend_words[4] = sat_sub(pend_words[4], gyro_off_x);
               pend_words[5] = sat_sub(pend_words[5], gyro_off_y);
               pend_words[6] = sat_sub(pend_words[6], gyro_off_z);
`endif
               pend = 1;
               in_frame = 0;
            end
         end else begin
            idle_cycles++;
            if (idle_cycles == GAP) begin
               m_err = 1;
               in_frame = 0;
            end
         end
      end
   endtask

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("frame_valid", 16'(frame_valid), 16'(m_fv));
      chk("frame_err", 16'(frame_err), 16'(m_err));
      chk("busy", 16'(busy), 16'(in_frame || pend));
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("accel_x", accel_x, m_words[0]);
      chk("accel_y", accel_y, m_words[1]);
      chk("accel_z", accel_z, m_words[2]);
      chk("temp", temp, m_words[3]);
      chk("gyro_x", gyro_x, m_words[4]);
      chk("gyro_y", gyro_y, m_words[5]);
      chk("gyro_z", gyro_z, m_words[6]);
   endtask

   // drive at posedge+1, let the next edge sample, compare at posedge+1
   task automatic cycle(bit fs, bit bv, logic [7:0] bd);
      frame_start = fs; byte_valid = bv; byte_data = bd;
      @(posedge clk);
      model_step(fs, bv, bd);
      #1;
      frame_start = 0; byte_valid = 0;
      compare_all();
   endtask

   task automatic idle(int n);
      repeat (n) cycle(0, 0, 8'h00);
   endtask

   task automatic do_reset(int n);
      rst_n = 0; frame_start = 0; byte_valid = 0;
      model_reset();
      #1;
      compare_all();
      repeat (n) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1;
   endtask

   typedef struct {
      bit fs; bit bv; logic [7:0] bd;
      bit fv; bit err; bit bsy;
   } vec_t;
   vec_t tbl[20];
   bit rfs, rbv;

   initial begin
      tbl[0]  = '{0, 1, 8'h55, 0, 0, 0};
      tbl[1]  = '{1, 0, 8'h00, 0, 0, 1};
      tbl[2]  = '{0, 1, 8'h11, 0, 0, 1};
      tbl[3]  = '{1, 1, 8'h22, 0, 1, 1};
      for (int i = 4; i <= 16; i++) tbl[i] = '{0, 1, 8'(8'h33 + i - 4), 0, 0, 1};
      tbl[17] = '{1, 1, 8'h77, 1, 0, 1};
      tbl[18] = '{1, 0, 8'h00, 0, 1, 1};
      tbl[19] = '{0, 0, 8'h00, 0, 0, 1};

      #1;
      do_reset(3);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_accel_x", accel_x, 16'h0000);

      // stray bytes with no frame_start
      for (int i = 0; i < 20; i++) cycle(0, 1, 8'($urandom));
      chk("stray_busy", 16'(busy), 16'h0);
      chk("stray_gyro_z", gyro_z, 16'h0000);

      // frame 0x01..0x0E, bytes 200 cycles apart
      cycle(1, 0, 8'h00);
      for (int i = 0; i < NB; i++) begin
         idle(199);
         cycle(0, 1, 8'(i + 1));
      end
      chk("lat_edge1_fv", 16'(frame_valid), 16'h0);
      cycle(0, 0, 8'h00);
      chk("lat_edge2_fv", 16'(frame_valid), 16'h1);
      chk("f1_accel_x", accel_x, 16'h0102);
      chk("f1_accel_z", accel_z, 16'h0506);
      chk("f1_temp", temp, 16'h0708);
      chk("f1_gyro_z", gyro_z, 16'h0D0E);
      chk("f1_cnt", frame_cnt, 16'd1);
      idle(2);

      // all-0xAA frame, then a partial frame that times out
      cycle(1, 1, 8'hAA);
      for (int i = 1; i < NB; i++) cycle(0, 1, 8'hAA);
      idle(2);
      cycle(1, 1, 8'h10);
      for (int i = 1; i < 5; i++) cycle(0, 1, 8'(8'h10 + i));
      idle(GAP - 1);
      cycle(0, 1, 8'h15);
      chk("gap_max_no_err", 16'(frame_err), 16'h0);
      idle(GAP - 1);
      chk("gap_pre_err", 16'(frame_err), 16'h0);
      cycle(0, 0, 8'h00);
      chk("timeout_err", 16'(frame_err), 16'h1);
      chk("timeout_busy", 16'(busy), 16'h0);
      chk("timeout_accel_x", accel_x, 16'hAAAA);
      chk("timeout_gyro_z", gyro_z, 16'hAAAA);
      chk("timeout_cnt", frame_cnt, 16'd2);
      cycle(0, 0, 8'h00);
      chk("timeout_err_once", 16'(frame_err), 16'h0);

      // abort by frame_start coinciding with a byte
      cycle(1, 0, 8'h00);
      for (int i = 0; i < 9; i++) cycle(0, 1, 8'(8'h30 + i));
      cycle(1, 1, 8'h80);
      chk("abort_err", 16'(frame_err), 16'h1);
      for (int i = 1; i < NB; i++) cycle(0, 1, 8'h00);
      cycle(0, 0, 8'h00);
      chk("abort_fv", 16'(frame_valid), 16'h1);
      chk("abort_accel_x", accel_x, 16'h8000);
      chk("abort_cnt", frame_cnt, 16'd3);
      idle(2);

      // reset after byte 10, then a full frame
      cycle(1, 0, 8'h00);
      for (int i = 0; i < 10; i++) cycle(0, 1, 8'(8'h40 + i));
      do_reset(3);
      idle(3);
      cycle(1, 0, 8'h00);
      for (int i = 0; i < NB; i++) cycle(0, 1, 8'(8'hC0 + i));
      cycle(0, 0, 8'h00);
      chk("rst_mid_cnt", frame_cnt, 16'd1);
      chk("rst_mid_accel_y", accel_y, 16'hC2C3);
      idle(2);

      // hand-derived vector table
      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].fs, tbl[i].bv, tbl[i].bd);
         chk("tbl_fv", 16'(frame_valid), 16'(tbl[i].fv));
         chk("tbl_err", 16'(frame_err), 16'(tbl[i].err));
         chk("tbl_busy", 16'(busy), 16'(tbl[i].bsy));
      end
      chk("tbl_accel_x", accel_x, 16'h2233);
      chk("tbl_cnt", frame_cnt, 16'd2);

`ifdef MPU_FRAME_GYRO_OFFSET_EN
      gyro_off_x = -16'sh0100;
      gyro_off_y = 16'sh0010;
      gyro_off_z = 16'sh0000;
      cycle(1, 0, 8'h00);
      for (int i = 0; i < 8; i++) cycle(0, 1, 8'h00);
      cycle(0, 1, 8'h7F); cycle(0, 1, 8'hF0);
      cycle(0, 1, 8'h00); cycle(0, 1, 8'h10);
      cycle(0, 1, 8'h12); cycle(0, 1, 8'h34);
      cycle(0, 0, 8'h00);
      chk("off_gyro_x_sat", gyro_x, 16'h7FFF);
      chk("off_gyro_y_zero", gyro_y, 16'h0000);
      chk("off_gyro_z", gyro_z, 16'h1234);
      gyro_off_x = 16'($urandom);
      gyro_off_y = 16'($urandom);
      gyro_off_z = 16'($urandom);
`endif

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rfs = ($urandom_range(0, 99) < 2);
         rbv = ($urandom_range(0, 99) < 45);
         cycle(rfs, rbv, 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
